sort_engine: RTL
================

// Module: sort_engine
// PURPOSE
//  Self-sequencing in-place exchange sorter over an external K-entry memory.
//  Combines the A/B register, i/j counter and comparator datapath with its controller FSM.
//  Adds a start/busy/done handshake, a runtime ascending/descending mode and a swap counter.
//  Width and depth are parametrised. Sits between the host and the shared data RAM.
//  The RAM reads combinationally (Dout = mem[Addr]) and writes on posedge clk when WE=1.
// PARAMETERS
//  W   8  data word width in bits
//  K   8  number of memory entries; must be >= 2
//  AW  $clog2(K)  address width (localparam)
//  SW  $clog2(K*(K-1)/2+1)  swap counter width (localparam)
// PORTS
//  clk       in   1   rising-edge clock
//  rst_n     in   1   asynchronous, active-low reset
//  start     in   1   begin a sort; sampled only in IDLE
//  desc      in   1   0 = ascending, 1 = descending; captured with start
//  abort     in   1   synchronous cancel; returns to IDLE with no done pulse
//  Dout      in   W   RAM read data for Addr, same cycle
//  Addr      out  AW  RAM address
//  Din       out  W   RAM write data
//  WE        out  1   RAM write enable
//  busy      out  1   high in every state except IDLE
//  done      out  1   one-cycle pulse at completion
//  swap_cnt  out  SW  number of swaps in the last/current sort
// BEHAVIOUR
//  Reset: state=IDLE; i_cnt, j_cnt, A_reg, B_reg, mode_q, swap_cnt = 0.
//   All outputs are 0 and there are no RAM writes.
//  Output decode: Addr, Din and WE are decoded from the state, i_cnt, j_cnt, A_reg and B_reg.
//  IDLE: if start, then i<=0, j<=1, mode_q<=desc, swap_cnt<=0, go to RD_A.
//  RD_A: Addr=i; A<=Dout; go to RD_B.
//  RD_B: Addr=j; B<=Dout; go to CMP.
//  CMP: swap = mode_q ? (A<B) : (A>B), unsigned compare.
//   Equal values never swap. If swap, go to WR_I; else go to NXT.
//  WR_I: Addr=i, Din=B, WE=1; go to WR_J.
//  WR_J: Addr=j, Din=A, WE=1; A<=B (tracks the new mem[i]); swap_cnt++; go to NXT.
//  NXT, case j!=K-1: j++; go to RD_B. A is reused, so mem[i] is not re-read.
//  NXT, case j==K-1 and i!=K-2: i++, j<=i+2; go to RD_A.
//  NXT, case j==K-1 and i==K-2: go to DONE.
//  DONE: done=1 for one cycle; go to IDLE. swap_cnt holds until the next start.
//  Latency: P=K(K-1)/2 pairs and S swaps.
//   busy is high for exactly (K-1) + 3P + 2S + 1 cycles, counting the DONE cycle.
//  Concurrent events: start while busy is ignored.
//   abort has priority over all transitions and goes to IDLE the next cycle.
//   A WE already asserted in the abort cycle still completes. Memory is left partially sorted.
//  Reset mid-sort: immediate return to IDLE, no further writes, no done pulse.
//  Counter width: i/j counters never exceed K-1. j<=i+2 is computed in AW+1 bits.
//   This prevents wrap when K is a power of two.
//  A RAM write only ever occurs in WR_I or WR_J.
// TESTING
//  1. K=4, mem=[4,3,2,1], asc: start=1 for 1 cycle.
//     -> mem=[1,2,3,4]; swap_cnt=6; busy high for 34 cycles; one done pulse.
//  2. K=8, mem=[90,25,60,15,30,75,45,10], desc=0.
//     -> mem=[10,15,25,30,45,60,75,90]; WE never high outside WR_I/WR_J.
//  3. Same data, desc=1 -> mem=[90,75,60,45,30,25,15,10]; one done pulse.
//  4. K=8, mem already ascending, asc -> swap_cnt=0; WE never asserted; busy high 92 cycles.
//  5. K=4, all entries =7 -> swap_cnt=0, mem unchanged.
//     Also: start pulsed while busy -> no restart, cycle count still 34.
//  6. Abort asserted at cycle 10 of test 1, then rst_n pulsed low mid-sort.
//     -> IDLE, no done pulse, busy=0 next cycle; outputs reset asynchronously to 0.

Source files
------------

// File: rtl/sort_if.sv
// Host/RAM bus of the in-place exchange sorter.
// Groups the start/busy/done handshake, the sort mode, abort, the swap
// counter and the combinational-read RAM port into a single bundle.
//   start, desc, abort : host -> sorter
//   busy, done, swap_cnt : sorter -> host
//   Dout : RAM -> sorter (read data for Addr, same cycle)
//   Addr, Din, WE : sorter -> RAM (write occurs on posedge clk when WE=1)
// Handshake: start is a level sampled only while busy=0; the sorter answers
// with busy high from the next cycle until after the single-cycle done
// pulse. abort cancels at the next edge with no done pulse.
interface sort_if #(
    parameter int W = 8,
    parameter int K = 8
);
    localparam int AW = $clog2(K);
    localparam int SW = $clog2(K * (K - 1) / 2 + 1);

    logic          start;
    logic          desc;
    logic          abort;
    logic [W-1:0]  Dout;
    logic [AW-1:0] Addr;
    logic [W-1:0]  Din;
    logic          WE;
    logic          busy;
    logic          done;
    logic [SW-1:0] swap_cnt;

    // Host/RAM side
    modport master (
        output start, desc, abort, Dout,
        input  Addr, Din, WE, busy, done, swap_cnt
    );

    // Sorter side
    modport slave (
        input  start, desc, abort, Dout,
        output Addr, Din, WE, busy, done, swap_cnt
    );
endinterface

// File: rtl/sort_engine.sv
// Self-sequencing in-place exchange sorter over an external K-entry RAM.
// For every pair (i, j) with i < j it reads both entries, compares them
// (ascending or descending, unsigned) and swaps them in memory when out of
// order. mem[i] is held in A across the inner j loop and updated after a
// swap, so it is read only once per outer pass.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : sort_if slave (start/desc/abort in, busy/done/swap_cnt out,
//           Dout in, Addr/Din/WE out)
module sort_engine #(
    parameter int W = 8,
    parameter int K = 8
) (
    input logic   clk,
    input logic   rst_n,
    sort_if.slave bus
);
    localparam int AW = $clog2(K);
    localparam int SW = $clog2(K * (K - 1) / 2 + 1);
    localparam logic [AW-1:0] LAST_J = AW'(K - 1);
    localparam logic [AW-1:0] LAST_I = AW'(K - 2);

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        CMP,
        WR_I,
        WR_J,
        NXT,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] i_q, i_d;
    logic [AW-1:0] j_q, j_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic          mode_q, mode_d;
    logic [SW-1:0] swap_cnt_q, swap_cnt_d;

    logic          swap;
    // One extra bit so i+2 cannot wrap when K is a power of two.
    logic [AW:0]   j_row_start;

    logic [AW-1:0] addr;
    logic [W-1:0]  din;
    logic          we;

    assign swap        = mode_q ? (a_q < b_q) : (a_q > b_q);
    assign j_row_start = {1'b0, i_q} + (AW + 1)'(2);

    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        j_d        = j_q;
        a_d        = a_q;
        b_d        = b_q;
        mode_d     = mode_q;
        swap_cnt_d = swap_cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    i_d        = '0;
                    j_d        = AW'(1);
                    mode_d     = bus.desc;
                    swap_cnt_d = '0;
                    state_d    = RD_A;
                end
            end
            RD_A: begin
                a_d     = bus.Dout;
                state_d = RD_B;
            end
            RD_B: begin
                b_d     = bus.Dout;
                state_d = CMP;
            end
            CMP: begin
                state_d = swap ? WR_I : NXT;
            end
            WR_I: begin
                state_d = WR_J;
            end
            WR_J: begin
                // A now mirrors the value just written to mem[i].
                a_d        = b_q;
                swap_cnt_d = swap_cnt_q + SW'(1);
                state_d    = NXT;
            end
            NXT: begin
                if (j_q != LAST_J) begin
                    j_d     = j_q + AW'(1);
                    state_d = RD_B;
                end else if (i_q != LAST_I) begin
                    i_d     = i_q + AW'(1);
                    j_d     = j_row_start[AW-1:0];
                    state_d = RD_A;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Abort overrides every transition; datapath updates of this cycle
        // (including a write already on the bus) still take effect.
        if (bus.abort) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            i_q        <= '0;
            j_q        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            mode_q     <= 1'b0;
            swap_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            a_q        <= a_d;
            b_q        <= b_d;
            mode_q     <= mode_d;
            swap_cnt_q <= swap_cnt_d;
        end
    end

    // RAM port decode: writes only ever happen in WR_I / WR_J.
    always_comb begin
        addr = '0;
        din  = '0;
        we   = 1'b0;
        case (state_q)
            RD_A: addr = i_q;
            RD_B: addr = j_q;
            WR_I: begin
                addr = i_q;
                din  = b_q;
                we   = 1'b1;
            end
            WR_J: begin
                addr = j_q;
                din  = a_q;
                we   = 1'b1;
            end
            default: begin
                addr = '0;
                din  = '0;
                we   = 1'b0;
            end
        endcase
    end

    assign bus.Addr     = addr;
    assign bus.Din      = din;
    assign bus.WE       = we;
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = (state_q == DONE);
    assign bus.swap_cnt = swap_cnt_q;
endmodule
